contador_pulsos: RTL

- Gated pulse counter and frequency meter. It counts rising edges of an asynchronous input over a fixed gate window of GATE_CYCLES clock cycles.
- At the end of each window it publishes the count with a one-cycle valid strobe.
- It is the measuring end of the divider chain: it consumes pulse trains such as divided-clock outputs or external events, and reports pulses per gate period (1 s at 100 MHz by default).

---
 rtl/contador_pulsos.sv | 92 +++++++++
 1 files changed

// File: rtl/contador_pulsos.sv
// contador_pulsos: gated rising-edge counter publishing pulses per GATE_CYCLES window
module contador_pulsos #(
  parameter int GATE_CYCLES = 100000000,
  parameter int COUNT_W     = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               pulso_in,
  output logic [COUNT_W-1:0] cuenta,
  output logic               valida,
  output logic               desborde,
  output logic               gate_activo
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam int AW = $clog2(SYNC_STAGES + 1);
  typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [AW-1:0] arm_q, arm_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [COUNT_W-1:0] acc_q, acc_d, acc_n, cuenta_q, cuenta_d;
  logic prev_q, prev_d, pend_q, pend_d, pend_n;
  logic valida_q, valida_d, desborde_q, desborde_d;
  logic edge_det, sat, last, run;
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pulso_in};
    prev_d     = sync_q[SYNC_STAGES-1];
    edge_det   = sync_q[SYNC_STAGES-1] & ~prev_q;
    sat        = edge_det & (&acc_q);
    acc_n      = (sat | ~edge_det) ? acc_q : acc_q + 1'b1;
    pend_n     = pend_q | sat;
    last       = gcnt_q == GW'(GATE_CYCLES - 1);
    run        = enable & ~last;
    state_d    = state_q;
    arm_d      = '0;
    gcnt_d     = '0;
    acc_d      = '0;
    pend_d     = 1'b0;
    valida_d   = 1'b0;
    cuenta_d   = cuenta_q;
    desborde_d = desborde_q;
    unique case (state_q)
      IDLE: state_d = enable ? ARM : IDLE;
      ARM: begin
        arm_d   = arm_q + 1'b1;
        state_d = !enable ? IDLE : (arm_q == AW'(SYNC_STAGES)) ? GATE : ARM;
      end
      GATE: begin
        // the last window cycle publishes even when enable has just dropped
        state_d    = enable ? GATE : IDLE;
        gcnt_d     = run ? gcnt_q + 1'b1 : '0;
        acc_d      = run ? acc_n : '0;
        pend_d     = run & pend_n;
        valida_d   = last;
        cuenta_d   = last ? acc_n : cuenta_q;
        desborde_d = last ? pend_n : desborde_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      arm_q      <= '0;
      gcnt_q     <= '0;
      acc_q      <= '0;
      pend_q     <= 1'b0;
      cuenta_q   <= '0;
      valida_q   <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      arm_q      <= arm_d;
      gcnt_q     <= gcnt_d;
      acc_q      <= acc_d;
      pend_q     <= pend_d;
      cuenta_q   <= cuenta_d;
      valida_q   <= valida_d;
      desborde_q <= desborde_d;
    end
  end
  assign cuenta      = cuenta_q;
  assign valida      = valida_q;
  assign desborde    = desborde_q;
  assign gate_activo = state_q == GATE;
endmodule
